// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan
//   Drives a 6-digit common-anode 7-segment display from the BCD hour/min/sec
//   counters. The three BCD bytes are captured once per frame, at the 5->0 wrap
//   of the digit index. Each digit is held for SCAN_DIV clocks. The module also
//   handles per-field blinking, hour leading-zero blanking and a '-' marker for
//   nibbles that are not valid BCD.
//
// Ports
//   clk        system clock, posedge
//   rst        asynchronous reset, active-low
//   en         scan enable; 0 freezes the scan and darkens the display
//   hour/min/sec  BCD bytes {tens,ones}
//   blink_sel  blink field select [2]=hour [1]=min [0]=sec
//   lz_blank   blank the hour tens digit when it is zero
//   seg        segments {g,f,e,d,c,b,a}, active-high
//   dp         decimal point, active-high
//   dig        one-hot active-low digit select, dig[0]=hour tens
//   frame      1-cycle pulse after the digit index wraps 5->0
module bcd_disp_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [2:0] blink_sel,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig,
  output logic       frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] p_q, p_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [23:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    dig_q, dig_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic          fld_blink;
  logic          lz_hit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // not BCD: show '-'
    endcase
    return s;
  endfunction

  always_comb begin
    tick        = en && (p_q == P_LAST);
    wrap        = tick && (idx_q == 3'd5);
    p_d         = p_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    snap_d      = snap_q;
    frame_d     = wrap;

    if (tick) begin
      p_d   = '0;
      idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    end else if (en) begin
      p_d = p_q + 1'b1;
    end

    if (wrap) begin
      snap_d = {hour, min, sec};
      if (blink_cnt_q == B_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Output path works from the pre-update idx/snapshot, so the display lags
  // the index by one clock but stays consistent with the captured frame.
  always_comb begin
    case (idx_q)
      3'd0:    nib = snap_q[23:20];
      3'd1:    nib = snap_q[19:16];
      3'd2:    nib = snap_q[15:12];
      3'd3:    nib = snap_q[11:8];
      3'd4:    nib = snap_q[7:4];
      default: nib = snap_q[3:0];
    endcase

    case (idx_q)
      3'd0, 3'd1: fld_blink = blink_ph_q && blink_sel[2];
      3'd2, 3'd3: fld_blink = blink_ph_q && blink_sel[1];
      default:    fld_blink = blink_ph_q && blink_sel[0];
    endcase

    lz_hit = (idx_q == 3'd0) && lz_blank && (snap_q[23:20] == 4'd0);

    seg_d = '0;
    dp_d  = 1'b0;
    dig_d = '1;
    if (en) begin
      dig_d = ~(6'b000001 << idx_q);
      if (!(fld_blink || lz_hit)) begin
        seg_d = seg_decode(nib);
      end
      dp_d = ((idx_q == 3'd1) || (idx_q == 3'd3)) && !fld_blink;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q         <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      snap_q      <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      dig_q       <= '1;
      frame_q     <= 1'b0;
    end else begin
      p_q         <= p_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      snap_q      <= snap_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      frame_q     <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign dig   = dig_q;
  assign frame = frame_q;

endmodule
